// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : mem_responder
//  Purpose  : Multi-cycle memory responder for the multi-cycle CPU. It serves
//             MemRead/MemWrite after WAIT_CYCLES wait states, gives a
//             one-cycle Ready pulse, and flags misaligned or unmapped
//             accesses through AddrError.
//  Options  : MEM_MMIO_EN adds an LED register at 0x4000_0000 and a read-only
//             free-running tick counter at 0x4000_0004.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        Ready,
  output logic        AddrError,
  output logic [7:0]  leds
);

  localparam int c_aw = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic [3:0]  r_cnt;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_is_write;
  logic [31:0] r_read_data;
  logic        r_addr_error;
  logic [31:0] r_mem [DEPTH_WORDS];

  logic            w_accept;
  logic            w_enter_done;
  logic            w_commit;
  logic [31:0]     w_acc_addr;
  logic            w_in_ram;
  logic [c_aw-1:0] w_idx;
  logic            w_mmio_hit;
  logic            w_fault;
  logic [31:0]     w_rd_value;

  // In IDLE the access being decoded is the one arriving on the inputs (this
  // matters when WAIT_CYCLES=0 and DONE follows IDLE directly); afterwards it
  // is the latched request.
  assign w_accept     = (r_state == S_IDLE) && (MemRead || MemWrite);
  assign w_acc_addr   = (r_state == S_IDLE) ? Address : r_addr;
  assign w_in_ram     = (w_acc_addr >> (c_aw + 2)) == 32'd0;
  assign w_idx        = w_acc_addr[c_aw+1:2];
  assign w_enter_done = (w_next_state == S_DONE);
  assign w_commit     = (r_state == S_DONE) && r_is_write && !r_addr_error;

`ifdef MEM_MMIO_EN
  logic [7:0]  r_leds;
  logic [31:0] r_tick;
  logic        w_hit_leds;
  logic        w_hit_tick;

  assign w_hit_leds = (w_acc_addr == 32'h4000_0000);
  assign w_hit_tick = (w_acc_addr == 32'h4000_0004);
  assign w_mmio_hit = w_hit_leds || w_hit_tick;
  assign leds       = r_leds;

  // Free-running tick counter, wraps naturally at 32 bits.
  always_ff @(posedge clk) begin
    if (reset) r_tick <= 32'd0;
    else       r_tick <= r_tick + 32'd1;
  end

  // LED register commits on the edge leaving DONE; tick writes are dropped.
  always_ff @(posedge clk) begin
    if (reset)                       r_leds <= 8'd0;
    else if (w_commit && w_hit_leds) r_leds <= r_wdata[7:0];
  end
`else
  assign w_mmio_hit = 1'b0;
  assign leds       = 8'd0;
`endif

  assign w_fault = (w_acc_addr[1:0] != 2'b00) || (!w_in_ram && !w_mmio_hit);

  // Read value for the access being decoded; faults read as zero.
  always_comb begin
    w_rd_value = r_mem[w_idx];
`ifdef MEM_MMIO_EN
    if (w_hit_leds) w_rd_value = {24'd0, r_leds};
    if (w_hit_tick) w_rd_value = r_tick;
`endif
    if (w_fault) w_rd_value = 32'd0;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  // Next-state decode.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_next_state = (WAIT_CYCLES == 0) ? S_DONE : S_WAIT;
      S_WAIT: if (r_cnt == 4'd1) w_next_state = S_DONE;
      S_DONE: w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Wait-state counter: loaded on accept, counts down while waiting.
  always_ff @(posedge clk) begin
    if (reset)                  r_cnt <= 4'd0;
    else if (w_accept)          r_cnt <= 4'(WAIT_CYCLES);
    else if (r_state == S_WAIT) r_cnt <= (r_cnt == 4'd1) ? 4'd0 : r_cnt - 4'd1;
  end

  // Request capture in IDLE; MemWrite wins when both strobes are high.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_addr     <= 32'd0;
      r_wdata    <= 32'd0;
      r_is_write <= 1'b0;
    end else if (w_accept) begin
      r_addr     <= Address;
      r_wdata    <= WriteData;
      r_is_write <= MemWrite;
    end
  end

  // Response registers, loaded on the edge entering DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_read_data  <= 32'd0;
      r_addr_error <= 1'b0;
    end else if (w_enter_done) begin
      r_read_data  <= w_rd_value;
      r_addr_error <= w_fault;
    end
  end

  // RAM write on the edge leaving DONE; contents survive reset.
  always_ff @(posedge clk) begin
    if (!reset && w_commit && w_in_ram) r_mem[w_idx] <= r_wdata;
  end

  assign ReadData  = r_read_data;
  assign Ready     = (r_state == S_DONE);
  assign AddrError = r_addr_error && (r_state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_responder
//  Purpose  : Scoreboard bench for mem_responder (default WAIT_CYCLES=2 plus
//             a WAIT_CYCLES=0 instance). MMIO checks follow MEM_MMIO_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_responder;

  localparam int c_wait = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemRead, MemWrite;
  logic [31:0] Address, WriteData;
  logic [31:0] ReadData;
  logic        Ready, AddrError;
  logic [7:0]  leds;

  logic        z_MemRead, z_MemWrite;
  logic [31:0] z_Address, z_WriteData;
  logic [31:0] z_ReadData;
  logic        z_Ready, z_AddrError;
  logic [7:0]  z_leds;

  always #5 clk = ~clk;

  mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(c_wait)) dut (
    .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite),
    .Address(Address), .WriteData(WriteData), .ReadData(ReadData),
    .Ready(Ready), .AddrError(AddrError), .leds(leds)
  );

  mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset), .MemRead(z_MemRead), .MemWrite(z_MemWrite),
    .Address(z_Address), .WriteData(z_WriteData), .ReadData(z_ReadData),
    .Ready(z_Ready), .AddrError(z_AddrError), .leds(z_leds)
  );

  typedef struct {
    logic [31:0] data;
    logic        err;
    bit          chk_data;
    int          cyc;
  } exp_t;

  exp_t        exp_q[$];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  int          ready_count = 0;
  int          last_ready_cyc = 0;
  logic [31:0] last_rdata = 32'd0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every Ready pulse of the main DUT is matched against the queue.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset && Ready) begin
        ready_count++;
        last_ready_cyc = cyc;
        last_rdata     = ReadData;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_ready: got Ready=1 expected no response (cycle %0d)", cyc);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("ready_latency", 32'(cyc), 32'(e.cyc));
          chk("addr_error", {31'd0, AddrError}, {31'd0, e.err});
          if (e.chk_data) chk("read_data", ReadData, e.data);
        end
      end
    end
  end

  // Issue one access on the main DUT, push its expectation, wait for Ready.
  task automatic access(input bit wr, input bit rd, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] exp_d,
                        input bit exp_e, input bit chk_d, output int issue_cyc);
    bit got;
    @(negedge clk);
    MemWrite  = wr;
    MemRead   = rd;
    Address   = a;
    WriteData = d;
    issue_cyc = cyc;
    exp_q.push_back('{exp_d, exp_e, chk_d, cyc + c_wait + 1});
    got = 1'b0;
    for (int i = 0; i < 30 && !got; i++) begin
      @(negedge clk);
      if (Ready) got = 1'b1;
    end
    #1;
    MemWrite = 1'b0;
    MemRead  = 1'b0;
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: got no Ready expected one for addr 0x%08h", a);
      exp_q.delete();
    end
  endtask

  // Issue one access on the zero-wait DUT and check it directly.
  task automatic access0(input bit wr, input logic [31:0] a, input logic [31:0] d,
                         input logic [31:0] exp_d, input bit chk_d);
    int c0;
    bit got;
    @(negedge clk);
    z_MemWrite  = wr;
    z_MemRead   = !wr;
    z_Address   = a;
    z_WriteData = d;
    c0  = cyc;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (z_Ready) begin
        got = 1'b1;
        chk("w0_latency", 32'(cyc - c0), 32'd1);
        chk("w0_addr_error", {31'd0, z_AddrError}, 32'd0);
        if (chk_d) chk("w0_read_data", z_ReadData, exp_d);
      end
    end
    #1;
    z_MemWrite = 1'b0;
    z_MemRead  = 1'b0;
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL w0_timeout: got no Ready expected one for addr 0x%08h", a);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c1, c2, c3, r1, rc;
    logic [31:0] v1, v2, v3;

    reset = 1'b1;
    MemRead = 1'b0; MemWrite = 1'b0; Address = 32'd0; WriteData = 32'd0;
    z_MemRead = 1'b0; z_MemWrite = 1'b0; z_Address = 32'd0; z_WriteData = 32'd0;
    repeat (3) @(negedge clk);
    chk("rst_ready", {31'd0, Ready}, 32'd0);
    chk("rst_read_data", ReadData, 32'd0);
    chk("rst_addr_error", {31'd0, AddrError}, 32'd0);
    chk("rst_leds", {24'd0, leds}, 32'd0);
    chk("rst_w0_ready", {31'd0, z_Ready}, 32'd0);
    reset = 1'b0;

    // Write then read back.
    access(1, 0, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0, 0, 0, c1);
    access(0, 1, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 0, 1, c1);

    // Faults: misaligned read, out-of-range write leaves word 0 alone.
    access(1, 0, 32'h0000_0000, 32'h1111_1111, 32'h0, 0, 0, c1);
    access(0, 1, 32'h0000_0013, 32'h0, 32'h0, 1, 1, c1);
    access(1, 0, 32'h0000_0400, 32'h0000_0BAD, 32'h0, 1, 0, c1);
    access(0, 1, 32'h0000_0000, 32'h0, 32'h1111_1111, 0, 1, c1);
    access(0, 1, 32'h0000_03FC, 32'h0, 32'h0, 0, 0, c1);

    // Both strobes high is a write; back-to-back read spaced 4 cycles.
    access(1, 1, 32'h0000_0020, 32'h0000_1234, 32'h0, 0, 0, c1);
    r1 = last_ready_cyc;
    access(0, 1, 32'h0000_0020, 32'h0, 32'h0000_1234, 0, 1, c1);
    chk("b2b_spacing", 32'(last_ready_cyc - r1), 32'd4);

    // Reset in WAIT drops the pending write.
    access(1, 0, 32'h0000_0008, 32'h0000_0000, 32'h0, 0, 0, c1);
    rc = ready_count;
    @(negedge clk);
    MemWrite = 1'b1; Address = 32'h0000_0008; WriteData = 32'h5555_5555;
    @(negedge clk);
    reset = 1'b1; MemWrite = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    repeat (8) @(negedge clk);
    chk("no_ready_after_reset", 32'(ready_count - rc), 32'd0);
    access(0, 1, 32'h0000_0008, 32'h0, 32'h0000_0000, 0, 1, c1);

`ifdef MEM_MMIO_EN
    access(1, 0, 32'h4000_0000, 32'h0000_00A5, 32'h0, 0, 0, c1);
    chk("leds_written", {24'd0, leds}, 32'h0000_00A5);
    access(0, 1, 32'h4000_0000, 32'h0, 32'h0000_00A5, 0, 1, c1);
    access(0, 1, 32'h4000_0008, 32'h0, 32'h0, 1, 1, c1);
    access(0, 1, 32'h4000_0004, 32'h0, 32'h0, 0, 0, c1);
    v1 = last_rdata;
    while (cyc < c1 + 9) @(negedge clk);
    access(0, 1, 32'h4000_0004, 32'h0, 32'h0, 0, 0, c2);
    v2 = last_rdata;
    chk("tick_delta", v2 - v1, 32'd10);
    access(1, 0, 32'h4000_0004, 32'h0000_0000, 32'h0, 0, 0, c3);
    access(0, 1, 32'h4000_0004, 32'h0, 32'h0, 0, 0, c3);
    v3 = last_rdata;
    chk("tick_unaffected", v3 - v1, 32'(c3 - c1));
`else
    access(1, 0, 32'h4000_0000, 32'h0000_00A5, 32'h0, 1, 0, c1);
    chk("leds_tied_low", {24'd0, leds}, 32'd0);
    access(0, 1, 32'h4000_0004, 32'h0, 32'h0, 1, 1, c1);
`endif

    // Zero-wait build: Ready in cycle 1.
    access0(1, 32'h0000_0004, 32'h0000_0077, 32'h0, 0);
    access0(0, 32'h0000_0004, 32'h0, 32'h0000_0077, 1);

    repeat (3) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
